kian_mem_arbiter: RTL

Two-master arbiter that shares the single-port simulation RAM between the kianv core (master 0) and a second requester (master 1: program loader / debug DMA). Both sides use the core's native valid/ready memory handshake. The arbiter grants one master at a time and forwards its request to the RAM port. It returns `rdata` and `ready` only to the granted master, and aborts with a fault if the RAM fails to answer within a bounded number of cycles. It sits between `kianv_modified`/loader and `ram` in the bench top.

---
 rtl/kian_mem_pkg.sv | 12 +
 rtl/kian_mem_arb_timer.sv | 28 ++
 rtl/kian_mem_arbiter.sv | 115 +++++++++++
 3 files changed

// File: rtl/kian_mem_pkg.sv
// Shared types and constants for the kianv memory arbiter.
package kian_mem_pkg;

  typedef enum logic {
    ARB_IDLE,
    ARB_BUSY
  } arb_state_t;

  localparam int KIAN_MEM_DATA_W = 32;
  localparam int KIAN_MEM_STRB_W = 4;

endpackage

// File: rtl/kian_mem_arb_timer.sv
// BUSY-phase timeout counter: expired flags the last allowed cycle of an access.
module kian_mem_arb_timer #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 8'd1;
    end
  end

  // The abort fires on LAST_COUNT, so the counter never reaches saturation.
  assign expired = enable && (count == LAST_COUNT);

endmodule

// File: rtl/kian_mem_arbiter.sv
// Two-master valid/ready arbiter in front of the single-port RAM.
// Define KIAN_MEM_ARB_RR_EN for round-robin; default is fixed priority to master 0.
module kian_mem_arbiter
  import kian_mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int ADDR_W         = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       m0_valid,
  input  logic [ADDR_W-1:0]          m0_addr,
  input  logic [KIAN_MEM_DATA_W-1:0] m0_wdata,
  input  logic [KIAN_MEM_STRB_W-1:0] m0_wstrb,
  output logic [KIAN_MEM_DATA_W-1:0] m0_rdata,
  output logic                       m0_ready,
  output logic                       m0_fault,
  input  logic                       m1_valid,
  input  logic [ADDR_W-1:0]          m1_addr,
  input  logic [KIAN_MEM_DATA_W-1:0] m1_wdata,
  input  logic [KIAN_MEM_STRB_W-1:0] m1_wstrb,
  output logic [KIAN_MEM_DATA_W-1:0] m1_rdata,
  output logic                       m1_ready,
  output logic                       m1_fault,
  output logic                       s_valid,
  output logic [ADDR_W-1:0]          s_addr,
  output logic [KIAN_MEM_DATA_W-1:0] s_wdata,
  output logic [KIAN_MEM_STRB_W-1:0] s_wstrb,
  input  logic [KIAN_MEM_DATA_W-1:0] s_rdata,
  input  logic                       s_ready,
  output logic                       grant
);

  arb_state_t state, state_next;
  logic       grant_next;
  logic       pick;
  logic       busy;
  logic       g_valid;
  logic       expired;

  assign busy    = (state == ARB_BUSY);
  assign g_valid = grant ? m1_valid : m0_valid;

  kian_mem_arb_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (!busy),
    .enable (busy),
    .expired(expired)
  );

`ifdef KIAN_MEM_ARB_RR_EN
  // Under contention, hand the bus to whichever master was not served last.
  assign pick = (m0_valid && m1_valid) ? ~grant : !m0_valid;
`else
  assign pick = !m0_valid;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ARB_IDLE;
      grant <= 1'b1;
    end else begin
      state <= state_next;
      grant <= grant_next;
    end
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    grant_next = grant;
    case (state)
      ARB_IDLE: begin
        if (m0_valid || m1_valid) begin
          state_next = ARB_BUSY;
          grant_next = pick;
        end
      end
      ARB_BUSY: begin
        // A master dropping valid mid-access abandons it without a ready pulse.
        if (!g_valid || s_ready || expired) begin
          state_next = ARB_IDLE;
        end
      end
      default: state_next = ARB_IDLE;
    endcase
  end

  always_comb begin
    logic                       done;
    logic                       fault;
    logic [KIAN_MEM_DATA_W-1:0] rdata;

    s_valid  = busy && g_valid;
    s_addr   = grant ? m1_addr  : m0_addr;
    s_wdata  = grant ? m1_wdata : m0_wdata;
    s_wstrb  = grant ? m1_wstrb : m0_wstrb;

    // s_ready wins over a coincident timeout.
    done  = s_valid && (s_ready || expired);
    fault = s_valid && !s_ready && expired;
    rdata = (s_valid && s_ready) ? s_rdata : '0;

    m0_ready = done && !grant;
    m0_fault = fault && !grant;
    m0_rdata = grant ? '0 : rdata;
    m1_ready = done && grant;
    m1_fault = fault && grant;
    m1_rdata = grant ? rdata : '0;
  end

endmodule
